// File: rtl/dma_engine.sv
// dma_engine
//   Sequences DMA transfers programmed by the MMIO register block.
//   H2D: host write stream beats become device memory writes.
//   D2H: device memory reads are buffered in a small FIFO and streamed out
//        as {data, D2H_TAG}, with the output path held for the whole transfer.
// Ports
//   aclk, aresetn                  clock, synchronous active-low reset
//   dma_start/direction/addrs/len  command from the register block
//   mmio_read_valid                register block still owns the output path
//   clear_dma_start, dma_status*,
//   dma_tx_len*, dma_output_active status back to the register block
//   h2d_*                          host write stream (in)
//   d2h_*                          output stream (out)
//   mem_rd_*                       read request (valid/ready) + in-order response
//   mem_wr_*                       write request (valid/ready)
module dma_engine #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] D2H_TAG    = 8'd3
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        dma_start,
  input  logic        dma_direction,
  input  logic [63:0] dma_src_addr,
  input  logic [63:0] dma_dst_addr,
  input  logic [63:0] dma_len,
  input  logic        mmio_read_valid,
  output logic        clear_dma_start,
  output logic        dma_status,
  output logic        dma_status_valid,
  output logic [63:0] dma_tx_len,
  output logic        dma_tx_len_valid,
  output logic        dma_output_active,
  input  logic [63:0] h2d_data,
  input  logic        h2d_valid,
  output logic        h2d_ready,
  output logic [71:0] d2h_data,
  output logic        d2h_valid,
  input  logic        d2h_ready,
  output logic        mem_rd_req,
  output logic [63:0] mem_rd_addr,
  input  logic        mem_rd_ready,
  input  logic [63:0] mem_rd_data,
  input  logic        mem_rd_valid,
  output logic        mem_wr_en,
  output logic [63:0] mem_wr_addr,
  output logic [63:0] mem_wr_data,
  output logic [7:0]  mem_wr_strb,
  input  logic        mem_wr_ready
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_H2D, S_D2H_WAIT, S_D2H, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          first_q;
  logic          status_q;
  logic [63:0]   txlen_q;
  logic [63:0]   src_q, dst_q, len_q;
  logic [60:0]   beats_q;
  logic [60:0]   bcnt_q;   // H2D writes done / D2H beats output
  logic [60:0]   rcnt_q;   // D2H reads issued
  logic [CW-1:0] outst_q;
  logic [CW-1:0] fcnt_q;
  logic [AW-1:0] wp_q, rp_q;
  logic [63:0]   fifo_q [FIFO_DEPTH];

  logic        go, last_beat, push, pop, rd_hs, wr_hs, credit;
  logic [2:0]  tail;
  logic [7:0]  tail_mask;
  logic [CW:0] credit_sum;
  logic [63:0] head_masked;

  assign go         = (state_q == S_IDLE) && dma_start;
  assign last_beat  = (bcnt_q == beats_q - 61'd1);
  assign tail       = len_q[2:0];
  assign tail_mask  = ~(8'hFF << tail);
  // Sum of in-flight reads and buffered beats never exceeds the FIFO size,
  // so responses (which cannot be stalled) always have a slot.
  assign credit_sum = {1'b0, outst_q} + {1'b0, fcnt_q};
  assign credit     = credit_sum < DEPTH_C;
  assign push       = (state_q == S_D2H) && mem_rd_valid;
  assign rd_hs      = mem_rd_req && mem_rd_ready;
  assign wr_hs      = mem_wr_en && mem_wr_ready;
  assign pop        = d2h_valid && d2h_ready;

  always_comb begin
    head_masked = fifo_q[rp_q];
    for (int b = 0; b < 8; b++)
      if (last_beat && tail != 3'd0 && !tail_mask[b]) head_masked[b*8 +: 8] = 8'h00;
  end

  always_comb begin
    state_d           = state_q;
    clear_dma_start   = first_q;
    dma_status        = status_q;
    dma_status_valid  = first_q || (state_q == S_DONE);
    dma_tx_len        = txlen_q;
    dma_tx_len_valid  = (state_q == S_DONE);
    dma_output_active = 1'b0;
    h2d_ready         = 1'b0;
    d2h_valid         = 1'b0;
    d2h_data          = '0;
    mem_rd_req        = 1'b0;
    mem_rd_addr       = '0;
    mem_wr_en         = 1'b0;
    mem_wr_addr       = '0;
    mem_wr_data       = '0;
    mem_wr_strb       = '0;
    unique case (state_q)
      S_IDLE: begin
        if (dma_start) begin
          if (dma_len == 64'd0)  state_d = S_DONE;
          else if (dma_direction) state_d = S_D2H_WAIT;
          else                    state_d = S_H2D;
        end
      end
      S_H2D: begin
        h2d_ready   = mem_wr_ready;
        mem_wr_en   = h2d_valid;
        mem_wr_addr = dst_q + {bcnt_q, 3'b000};
        mem_wr_data = h2d_data;
        mem_wr_strb = (last_beat && tail != 3'd0) ? tail_mask : 8'hFF;
        if (wr_hs && last_beat) state_d = S_DONE;
      end
      S_D2H_WAIT: begin
        dma_output_active = 1'b1;
        if (!mmio_read_valid) state_d = S_D2H;
      end
      S_D2H: begin
        dma_output_active = 1'b1;
        mem_rd_req        = (rcnt_q != beats_q) && credit;
        mem_rd_addr       = mem_rd_req ? src_q + {rcnt_q, 3'b000} : 64'd0;
        d2h_valid         = (fcnt_q != '0);
        d2h_data          = d2h_valid ? {head_masked, D2H_TAG} : 72'd0;
        if (pop && last_beat) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      first_q  <= 1'b0;
      status_q <= 1'b0;
      txlen_q  <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      beats_q  <= '0;
      bcnt_q   <= '0;
      rcnt_q   <= '0;
      outst_q  <= '0;
      fcnt_q   <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
    end else begin
      state_q <= state_d;
      first_q <= (state_q == S_IDLE) && (state_d != S_IDLE);
      if (go) begin
        src_q   <= dma_src_addr & ~64'h7;
        dst_q   <= dma_dst_addr & ~64'h7;
        len_q   <= dma_len;
        beats_q <= dma_len[63:3] + 61'(|dma_len[2:0]);
        bcnt_q  <= '0;
        rcnt_q  <= '0;
        outst_q <= '0;
        fcnt_q  <= '0;
        wp_q    <= '0;
        rp_q    <= '0;
        if (state_d != S_DONE) status_q <= 1'b0;
      end else begin
        if (wr_hs || pop) bcnt_q <= bcnt_q + 61'd1;
        if (rd_hs)        rcnt_q <= rcnt_q + 61'd1;
        outst_q <= outst_q + CW'(rd_hs) - CW'(push);
        fcnt_q  <= fcnt_q + CW'(push) - CW'(pop);
        if (push) wp_q <= wp_q + AW'(1);
        if (pop)  rp_q <= rp_q + AW'(1);
      end
      if (state_d == S_DONE && state_q != S_DONE) begin
        status_q <= 1'b1;
        txlen_q  <= go ? dma_len : len_q;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (push) fifo_q[wp_q] <= mem_rd_data;
  end
endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine
//   Randomized bench for dma_engine. A negedge process drives readies, the
//   host stream and an in-order memory responder, then logs every handshake.
//   Each scenario task compares the logs with a transfer-level model.
module tb_dma_engine;
  localparam int FD = 4;

  logic        aclk = 1'b0, aresetn = 1'b0;
  logic        dma_start = 0, dma_direction = 0, mmio_read_valid = 0;
  logic [63:0] dma_src_addr = 0, dma_dst_addr = 0, dma_len = 0;
  logic        clear_dma_start, dma_status, dma_status_valid, dma_tx_len_valid, dma_output_active;
  logic [63:0] dma_tx_len;
  logic [63:0] h2d_data = 0;
  logic        h2d_valid = 0, h2d_ready;
  logic [71:0] d2h_data;
  logic        d2h_valid, d2h_ready = 0;
  logic        mem_rd_req, mem_rd_ready = 0, mem_rd_valid = 0;
  logic [63:0] mem_rd_addr, mem_rd_data = 0;
  logic        mem_wr_en, mem_wr_ready = 0;
  logic [63:0] mem_wr_addr, mem_wr_data;
  logic [7:0]  mem_wr_strb;

  always #5 aclk = ~aclk;

  dma_engine #(.FIFO_DEPTH(FD), .D2H_TAG(8'd3)) dut (
    .aclk(aclk), .aresetn(aresetn), .dma_start(dma_start), .dma_direction(dma_direction),
    .dma_src_addr(dma_src_addr), .dma_dst_addr(dma_dst_addr), .dma_len(dma_len),
    .mmio_read_valid(mmio_read_valid), .clear_dma_start(clear_dma_start),
    .dma_status(dma_status), .dma_status_valid(dma_status_valid),
    .dma_tx_len(dma_tx_len), .dma_tx_len_valid(dma_tx_len_valid),
    .dma_output_active(dma_output_active),
    .h2d_data(h2d_data), .h2d_valid(h2d_valid), .h2d_ready(h2d_ready),
    .d2h_data(d2h_data), .d2h_valid(d2h_valid), .d2h_ready(d2h_ready),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ready(mem_rd_ready),
    .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_strb(mem_wr_strb), .mem_wr_ready(mem_wr_ready)
  );

  int checks = 0, errors = 0, cyc = 0;

  typedef struct { logic [63:0] addr; logic [63:0] data; logic [7:0] strb; } wr_t;
  typedef struct { int due; logic [63:0] data; } rsp_t;

  wr_t         wr_log[$];
  int          wr_cyc[$], out_cyc[$];
  logic [63:0] rd_log[$];
  logic [71:0] out_log[$];
  bit          st_log[$], done_act[$];
  logic [63:0] tl_log[$];
  logic [63:0] h2d_src[$], h2d_sent[$];
  rsp_t        rsp_q[$];
  logic [63:0] mem_ov [logic [63:0]];
  int          clr_cnt, prot_err, inflight, max_inflight;
  int          rd_lat = 1, d2h_mode = 0;
  bit          full_rdy = 1, tog, h2d_hold;
  bit          prev_rd_pend, prev_out_pend;
  logic [63:0] prev_rd_addr;
  logic [71:0] prev_out;

  function automatic logic [63:0] memf(input logic [63:0] a);
    if (mem_ov.exists(a)) return mem_ov[a];
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'hDEAD_BEEF_0BAD_F00D;
  endfunction

  // Environment: drive at negedge, sample handshakes 1ns later.
  always @(negedge aclk) begin
    rsp_t r;
    cyc++;
    mem_rd_ready = full_rdy ? 1'b1 : 1'($urandom_range(0, 1));
    mem_wr_ready = full_rdy ? 1'b1 : 1'($urandom_range(0, 1));
    if (d2h_mode == 1) begin tog = !tog; d2h_ready = tog; end
    else d2h_ready = full_rdy ? 1'b1 : 1'($urandom_range(0, 1));
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      mem_rd_valid = 1'b1; mem_rd_data = rsp_q[0].data;
      void'(rsp_q.pop_front()); inflight--;
    end else begin
      mem_rd_valid = 1'b0; mem_rd_data = {$urandom, $urandom};
    end
    if (h2d_src.size() > 0) begin
      h2d_valid = h2d_hold || full_rdy || 1'($urandom_range(0, 1));
      h2d_data  = h2d_src[0];
    end else h2d_valid = 1'b0;
    #1;
    if (!aresetn) begin
      prev_rd_pend = 0; prev_out_pend = 0; h2d_hold = 0;
    end else begin
      if (d2h_valid && !dma_output_active) prot_err++;
      if (prev_rd_pend && (!mem_rd_req || mem_rd_addr != prev_rd_addr)) prot_err++;
      if (prev_out_pend && (!d2h_valid || d2h_data != prev_out)) prot_err++;
      prev_rd_pend = mem_rd_req && !mem_rd_ready; prev_rd_addr = mem_rd_addr;
      prev_out_pend = d2h_valid && !d2h_ready;    prev_out = d2h_data;
      if (mem_rd_req && mem_rd_ready) begin
        rd_log.push_back(mem_rd_addr);
        r.due = cyc + rd_lat; r.data = memf(mem_rd_addr);
        rsp_q.push_back(r);
        inflight++;
        if (inflight > max_inflight) max_inflight = inflight;
      end
      if (mem_wr_en && mem_wr_ready) begin
        wr_t w; w.addr = mem_wr_addr; w.data = mem_wr_data; w.strb = mem_wr_strb;
        wr_log.push_back(w); wr_cyc.push_back(cyc);
      end
      if (h2d_valid && h2d_ready) begin void'(h2d_src.pop_front()); h2d_hold = 0; end
      else h2d_hold = h2d_valid;
      if (d2h_valid && d2h_ready) begin out_log.push_back(d2h_data); out_cyc.push_back(cyc); end
      if (dma_status_valid) st_log.push_back(dma_status);
      if (dma_tx_len_valid) begin tl_log.push_back(dma_tx_len); done_act.push_back(dma_output_active); end
      if (clear_dma_start) clr_cnt++;
    end
  end

  task automatic tick();
    @(negedge aclk); #2;
  endtask

  function automatic bit outs_zero();
    return (|{clear_dma_start, dma_status, dma_status_valid, dma_tx_len, dma_tx_len_valid,
              dma_output_active, h2d_ready, d2h_data, d2h_valid, mem_rd_req, mem_rd_addr,
              mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_strb}) === 1'b0;
  endfunction

  task automatic clear_logs();
    wr_log.delete(); wr_cyc.delete(); rd_log.delete(); out_log.delete(); out_cyc.delete();
    st_log.delete(); tl_log.delete(); done_act.delete();
    clr_cnt = 0; prot_err = 0; max_inflight = inflight;
  endtask

  task automatic load_h2d(input int nbeats);
    h2d_src.delete(); h2d_sent.delete();
    for (int i = 0; i < nbeats; i++) begin
      logic [63:0] d = {$urandom, $urandom};
      h2d_src.push_back(d); h2d_sent.push_back(d);
    end
  endtask

  task automatic start_xfer(input bit dir, input logic [63:0] src, dst, len, input int hold);
    clear_logs();
    dma_direction = dir; dma_src_addr = src; dma_dst_addr = dst; dma_len = len;
    dma_start = 1'b1; mmio_read_valid = (hold > 0);
    tick();
    checks++;
    if (clear_dma_start !== 1'b1) begin
      errors++; $display("FAIL start_latency clear_dma_start=%b expected 1", clear_dma_start);
    end
    dma_start = 1'b0;
    for (int i = 0; i < hold; i++) begin
      checks++;
      if (mem_rd_req !== 1'b0 || d2h_valid !== 1'b0 || dma_output_active !== 1'b1) begin
        errors++;
        $display("FAIL d2h_wait cyc%0d rd_req=%b d2h_valid=%b active=%b expected 0 0 1",
                 i, mem_rd_req, d2h_valid, dma_output_active);
      end
      if (i == hold - 1) mmio_read_valid = 1'b0;
      else tick();
    end
  endtask

  // Transfer-level reference: ceil(len/8) beats at aligned base + 8*i,
  // partial last beat trimmed to len%8 bytes.
  task automatic finish_xfer(input bit dir, input logic [63:0] src, dst, len);
    logic [63:0] n, base;
    int t, tail;
    bit ok;
    n    = len / 8 + ((len % 8) != 0 ? 64'd1 : 64'd0);
    tail = int'(len % 8);
    for (t = 0; t < 3000 && tl_log.size() == 0; t++) tick();
    checks++;
    if (tl_log.size() == 0) begin
      errors++; $display("FAIL done_timeout no tx_len strobe after %0d cycles expected 1", t);
      return;
    end
    repeat (4) tick();
    checks++;
    if (clr_cnt != 1) begin errors++; $display("FAIL clear_pulses got %0d expected 1", clr_cnt); end
    ok = (len == 0) ? (st_log.size() == 1 && st_log[0] == 1)
                    : (st_log.size() == 2 && st_log[0] == 0 && st_log[1] == 1);
    checks++;
    if (!ok) begin errors++; $display("FAIL status_seq got %0d strobes expected %0d", st_log.size(), (len == 0) ? 1 : 2); end
    checks++;
    if (tl_log.size() != 1 || tl_log[0] != len) begin
      errors++; $display("FAIL tx_len got %0h expected %0h", tl_log[0], len);
    end
    checks++;
    if (prot_err != 0) begin errors++; $display("FAIL protocol violations got %0d expected 0", prot_err); end
    if (dir == 1'b0) begin
      base = dst & ~64'h7;
      checks++;
      if (wr_log.size() != int'(n) || rd_log.size() != 0 || out_log.size() != 0) begin
        errors++; $display("FAIL h2d_count writes=%0d reads=%0d outs=%0d expected %0d 0 0",
                           wr_log.size(), rd_log.size(), out_log.size(), n);
      end
      for (int i = 0; i < wr_log.size() && i < int'(n); i++) begin
        logic [7:0] s = 8'hFF;
        if (i == int'(n) - 1 && tail != 0) s = 8'((1 << tail) - 1);
        checks++;
        if (wr_log[i].addr != base + 64'(8 * i) || wr_log[i].data != h2d_sent[i] || wr_log[i].strb != s) begin
          errors++;
          $display("FAIL h2d_beat%0d got a=%h d=%h s=%h expected a=%h d=%h s=%h", i,
                   wr_log[i].addr, wr_log[i].data, wr_log[i].strb, base + 64'(8 * i), h2d_sent[i], s);
        end
      end
      checks++;
      if (h2d_src.size() != h2d_sent.size() - int'(n)) begin
        errors++; $display("FAIL h2d_extra leftover=%0d expected %0d", h2d_src.size(), h2d_sent.size() - int'(n));
      end
    end else begin
      base = src & ~64'h7;
      checks++;
      if (rd_log.size() != int'(n) || out_log.size() != int'(n) || wr_log.size() != 0) begin
        errors++; $display("FAIL d2h_count reads=%0d outs=%0d writes=%0d expected %0d %0d 0",
                           rd_log.size(), out_log.size(), wr_log.size(), n, n);
      end
      for (int i = 0; i < out_log.size() && i < int'(n); i++) begin
        logic [63:0] a, d;
        a = base + 64'(8 * i);
        d = memf(a);
        if (i == int'(n) - 1 && tail != 0)
          for (int b = tail; b < 8; b++) d[b*8 +: 8] = 8'h00;
        checks++;
        if (rd_log[i] != a || out_log[i] != {d, 8'h03}) begin
          errors++; $display("FAIL d2h_beat%0d got rd=%h out=%h expected rd=%h out=%h",
                             i, rd_log[i], out_log[i], a, {d, 8'h03});
        end
      end
      checks++;
      if (max_inflight > FD) begin errors++; $display("FAIL inflight max=%0d expected <=%0d", max_inflight, FD); end
      checks++;
      if (done_act[0] !== 1'b0) begin errors++; $display("FAIL active_in_done got %b expected 0", done_act[0]); end
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0; dma_start = 0; mmio_read_valid = 0;
    tick();
    checks++;
    if (!outs_zero()) begin errors++; $display("FAIL reset_outputs nonzero output expected all 0"); end
    tick();
    rsp_q.delete(); inflight = 0; h2d_src.delete();
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    full_rdy = 1; d2h_mode = 0; rd_lat = 1;
    do_reset();
    tick();
    checks++;
    if (!outs_zero()) begin errors++; $display("FAIL idle_outputs nonzero output expected all 0"); end
  endtask

  task automatic test_h2d();
    full_rdy = 1;
    load_h2d(4);
    start_xfer(0, 64'h0, 64'h1000, 64'd20, 0);
    finish_xfer(0, 64'h0, 64'h1000, 64'd20);
    checks++;
    if (wr_log.size() != 3 || wr_log[2].addr != 64'h1010 || wr_log[2].strb != 8'h0F) begin
      errors++; $display("FAIL h2d_20_last got n=%0d a=%h s=%h expected 3 1010 0f",
                         wr_log.size(), wr_log[2].addr, wr_log[2].strb);
    end
  endtask

  task automatic test_d2h();
    full_rdy = 1; rd_lat = 2;
    mem_ov[64'h200] = 64'h1122334455667788;
    mem_ov[64'h208] = 64'h99AABBCCDDEEFF00;
    start_xfer(1, 64'h200, 64'h0, 64'd12, 0);
    finish_xfer(1, 64'h200, 64'h0, 64'd12);
    checks++;
    if (out_log.size() != 2 || out_log[0] != {64'h1122334455667788, 8'h03}
        || out_log[1] != {64'h00000000DDEEFF00, 8'h03}) begin
      errors++; $display("FAIL d2h_12 got %h %h expected 112233445566778803 00000000ddeeff0003",
                         out_log[0], out_log[1]);
    end
  endtask

  task automatic test_d2h_wait();
    full_rdy = 1; rd_lat = 1;
    start_xfer(1, 64'h4000, 64'h0, 64'd24, 3);
    finish_xfer(1, 64'h4000, 64'h0, 64'd24);
  endtask

  task automatic test_backpressure();
    full_rdy = 1; rd_lat = 6; d2h_mode = 1;
    start_xfer(1, 64'h8008, 64'h0, 64'd128, 0);
    finish_xfer(1, 64'h8008, 64'h0, 64'd128);
    d2h_mode = 0;
  endtask

  task automatic test_len0();
    full_rdy = 1; rd_lat = 1;
    for (int d = 0; d < 2; d++) begin
      load_h2d(2);
      start_xfer(1'(d), 64'h300, 64'h500, 64'd0, 0);
      finish_xfer(1'(d), 64'h300, 64'h500, 64'd0);
    end
  endtask

  task automatic test_throughput();
    full_rdy = 1; rd_lat = 1;
    load_h2d(8);
    start_xfer(0, 64'h0, 64'h2000, 64'd64, 0);
    finish_xfer(0, 64'h0, 64'h2000, 64'd64);
    checks++;
    if (wr_cyc.size() != 8 || wr_cyc[7] - wr_cyc[0] != 7) begin
      errors++; $display("FAIL h2d_rate span=%0d expected 7", wr_cyc[wr_cyc.size()-1] - wr_cyc[0]);
    end
    start_xfer(1, 64'h3000, 64'h0, 64'd64, 0);
    finish_xfer(1, 64'h3000, 64'h0, 64'd64);
    checks++;
    if (out_cyc.size() != 8 || out_cyc[7] - out_cyc[0] != 7) begin
      errors++; $display("FAIL d2h_rate span=%0d expected 7", out_cyc[out_cyc.size()-1] - out_cyc[0]);
    end
  endtask

  task automatic test_wrap();
    full_rdy = 1;
    load_h2d(3);
    start_xfer(0, 64'h0, 64'hFFFF_FFFF_FFFF_FFF3, 64'd24, 0);
    finish_xfer(0, 64'h0, 64'hFFFF_FFFF_FFFF_FFF3, 64'd24);
  endtask

  task automatic test_reset_mid();
    int t;
    full_rdy = 1; rd_lat = 3;
    start_xfer(1, 64'h6000, 64'h0, 64'd64, 0);
    for (t = 0; t < 200 && out_log.size() < 2; t++) tick();
    checks++;
    if (out_log.size() < 2) begin errors++; $display("FAIL mid_timeout outs=%0d expected 2", out_log.size()); end
    do_reset();
    tick();
    start_xfer(1, 64'h6000, 64'h0, 64'd64, 0);
    finish_xfer(1, 64'h6000, 64'h0, 64'd64);
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      bit          dir = 1'($urandom_range(0, 1));
      logic [63:0] len = 64'($urandom_range(0, 80));
      logic [63:0] src = {$urandom, $urandom};
      logic [63:0] dst = {$urandom, $urandom};
      full_rdy = 1'($urandom_range(0, 1));
      rd_lat   = $urandom_range(1, 8);
      load_h2d(int'((len + 7) / 8) + $urandom_range(0, 2));
      start_xfer(dir, src, dst, len, dir ? $urandom_range(0, 2) : 0);
      finish_xfer(dir, src, dst, len);
    end
  endtask

  initial begin
    test_reset();
    test_h2d();
    test_d2h();
    test_d2h_wait();
    test_backpressure();
    test_len0();
    test_throughput();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
